// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mips_mem_pkg;

  // Access sequencer states: idle, first word on the port, second word, data return
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    LAST = 2'd3
  } state_t;

  // The memory writes a byte store at mem_addr + 3, so the controller pre-subtracts it
  localparam int unsigned BYTE_STORE_OFFSET = 3;
  // Byte distance between the two words of a paired (double) access
  localparam int unsigned DOUBLE_STRIDE     = 4;

  // Request fields latched from the EX/MEM register at accept
  typedef struct packed {
    logic        write;
    logic        dbl;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wdata2;
  } mem_req_t;

endpackage

// File: rtl/mem_access_ctrl_align_chk.sv
// Combinational legality check for a memory request: alignment and byte-load rejection.
module mem_align_chk (
  input  logic [2:0] addr_lo_i,
  input  logic       dbl_i,
  input  logic       byt_i,
  input  logic       write_i,
  output logic       ok_o
);

  logic aligned;

  // Doubles need 8-byte alignment, words 4-byte, byte stores any address; byte loads do not exist
  always_comb begin
    aligned = 1'b0;
    if (dbl_i) begin
      aligned = (addr_lo_i == 3'b000);
    end else if (byt_i) begin
      aligned = 1'b1;
    end else begin
      aligned = (addr_lo_i[1:0] == 2'b00);
    end
    ok_o = aligned & ~(byt_i & ~write_i);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: sequences load/store requests (single, double, byte) onto a
// single-word memory port and stalls the pipeline until each access completes.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_double,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wdata2,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] resp_rdata2,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_store_byte,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Read data is only captured when the memory answers one cycle after the strobe
  localparam logic RD_LAT_OK = (MEM_RD_LAT == 1);

  state_t            state_q, state_d;
  mem_req_t          req_q, req_d, req_in;
  logic              resp_valid_q, resp_valid_d;
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [DATA_W-1:0] resp_rdata2_q, resp_rdata2_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_store_byte_q, mem_store_byte_d;
  logic              accept;
  logic              req_ok;

  // While resp_valid is high the EX/MEM register still holds the finished instruction
  assign accept = (state_q == IDLE) & req_valid & ~resp_valid_q;

  assign req_in = '{write:  req_write,
                    dbl:    req_double,
                    byt:    req_byte,
                    addr:   req_addr,
                    wdata:  req_wdata,
                    wdata2: req_wdata2};

  mem_align_chk u_align_chk (
    .addr_lo_i (req_addr[2:0]),
    .dbl_i     (req_double),
    .byt_i     (req_byte),
    .write_i   (req_write),
    .ok_o      (req_ok)
  );

  // Next-state and registered-output logic for the access sequencer
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    resp_valid_d     = 1'b0;
    addr_err_d       = 1'b0;
    resp_rdata_d     = resp_rdata_q;
    resp_rdata2_d    = resp_rdata2_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_write_d      = 1'b0;
    mem_read_d       = 1'b0;
    mem_store_byte_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = req_in;
          if (req_ok) begin
            state_d          = W0;
            mem_addr_d       = req_byte ? (req_addr - ADDR_W'(BYTE_STORE_OFFSET)) : req_addr;
            mem_wdata_d      = req_wdata;
            mem_write_d      = req_write;
            mem_read_d       = ~req_write;
            mem_store_byte_d = req_byte;
          end else begin
            resp_valid_d = 1'b1;
            addr_err_d   = 1'b1;
          end
        end
      end

      W0: begin
        // Doubles put word 1 on the bus; singles keep word 0 on the (unstrobed) bus
        mem_wdata_d = req_q.dbl ? req_q.wdata2 : req_q.wdata;
        if (req_q.dbl) begin
          state_d          = W1;
          mem_addr_d       = req_q.addr + ADDR_W'(DOUBLE_STRIDE);
          mem_write_d      = req_q.write;
          mem_read_d       = ~req_q.write;
          mem_store_byte_d = req_q.byt;
        end else begin
          state_d = LAST;
        end
      end

      W1: begin
        if (~req_q.write && RD_LAT_OK) begin
          resp_rdata_d = mem_rdata;
        end
        state_d = LAST;
      end

      LAST: begin
        if (~req_q.write && RD_LAT_OK) begin
          if (req_q.dbl) begin
            resp_rdata2_d = mem_rdata;
          end else begin
            resp_rdata_d = mem_rdata;
          end
        end
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, response and memory-port registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      resp_valid_q     <= 1'b0;
      addr_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      resp_rdata2_q    <= '0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_store_byte_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      resp_valid_q     <= resp_valid_d;
      addr_err_q       <= addr_err_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_rdata2_q    <= resp_rdata2_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_write_q      <= mem_write_d;
      mem_read_q       <= mem_read_d;
      mem_store_byte_q <= mem_store_byte_d;
    end
  end

  // Latched request fields; only meaningful after an accept, so no reset is needed
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  assign stall          = (state_q != IDLE) | (req_valid & ~resp_valid_q);
  assign resp_valid     = resp_valid_q;
  assign addr_err       = addr_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_rdata2    = resp_rdata2_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;
  assign mem_store_byte = mem_store_byte_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset/hold-over
// sequences and randomized requests against a byte-level memory reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_double, req_byte;
  logic [31:0] req_addr, req_wdata, req_wdata2;
  logic        stall, resp_valid, addr_err;
  logic [31:0] resp_rdata, resp_rdata2;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, mem_store_byte;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_double     (req_double),
    .req_byte       (req_byte),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wdata2     (req_wdata2),
    .stall          (stall),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_rdata2    (resp_rdata2),
    .addr_err       (addr_err),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_store_byte (mem_store_byte),
    .mem_rdata      (mem_rdata)
  );

  // ---------------- memory device (big-endian, 256 bytes, 1-cycle read) ----------------
  logic [31:0] tmem [0:63];
  logic [31:0] byte_ea;
  int          byte_lane;
  assign byte_ea   = mem_addr + 32'd3;
  assign byte_lane = 3 - int'(byte_ea[1:0]);

  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_store_byte) tmem[byte_ea[7:2]][8*byte_lane +: 8] <= mem_wdata[7:0];
      else                tmem[mem_addr[7:2]] <= mem_wdata;
    end
    if (mem_read) mem_rdata <= tmem[mem_addr[7:2]];
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [0:63];
  logic [31:0] ref_rd, ref_rd2;
  int tests = 0, fails = 0;
  int strobe_cnt = 0, exp_strobe_cnt = 0;

  always @(negedge clk) if (mem_read || mem_write) strobe_cnt++;

  typedef struct {
    logic        wr, dbl, byt;
    logic [31:0] addr, wd, wd2;
  } req_t;

  typedef struct {
    req_t        rq;
    logic        err;
    logic [31:0] rd, rd2;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic req_t mkr(logic wr, logic dbl, logic byt, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] wd2);
    req_t r;
    r.wr = wr; r.dbl = dbl; r.byt = byt; r.addr = a; r.wd = wd; r.wd2 = wd2;
    return r;
  endfunction

  function automatic vec_t mkv(req_t r, logic e, logic [31:0] rd, logic [31:0] rd2);
    vec_t v;
    v.rq = r; v.err = e; v.rd = rd; v.rd2 = rd2;
    return v;
  endfunction

  // Issue one request starting just after a rising edge; keep req_valid high through the
  // response cycle (as the pipeline does), check against the model, end just after an edge.
  task automatic do_req(input req_t r, output logic got_err,
                        output logic [31:0] got_rd, output logic [31:0] got_rd2);
    logic        legal;
    int          exp_n, exp_lat, lat, n, lane;
    int          sc [4];
    logic [31:0] sa [4];
    logic [31:0] sd [4];
    logic [3:0]  sw, sr, sb;
    bit          done;
    logic [31:0] a0;

    legal   = !(r.byt && !r.wr) &&
              (r.dbl ? (r.addr[2:0] == 3'd0) : (r.byt || r.addr[1:0] == 2'd0));
    exp_n   = legal ? (r.dbl ? 2 : 1) : 0;
    exp_lat = legal ? (r.dbl ? 4 : 3) : 1;
    a0      = r.byt ? r.addr - 32'd3 : r.addr;

    req_valid = 1'b1; req_write = r.wr; req_double = r.dbl; req_byte = r.byt;
    req_addr  = r.addr; req_wdata = r.wd; req_wdata2 = r.wd2;

    got_err = 1'b0; got_rd = '0; got_rd2 = '0;
    sw = '0; sr = '0; sb = '0;
    n = 0; lat = 0; done = 0;
    @(negedge clk);
    chk("stall_in_accept_cycle", stall, 1'b1);
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_read || mem_write) begin
        if (n < 4) begin
          sc[n] = lat; sa[n] = mem_addr; sd[n] = mem_wdata;
          sw[n] = mem_write; sr[n] = mem_read; sb[n] = mem_store_byte;
        end
        n++;
      end
      if (resp_valid) begin
        done    = 1;
        got_err = addr_err;
        got_rd  = resp_rdata;
        got_rd2 = resp_rdata2;
        chk("stall_in_resp_cycle", stall, 1'b0);
      end
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    chk("latency", lat, exp_lat);
    chk("strobe_count", n, exp_n);
    if (n >= 1 && exp_n >= 1) begin
      chk("w0_cycle", sc[0], 32'd1);
      chk("w0_addr", sa[0], a0);
      chk("w0_write", sw[0], r.wr);
      chk("w0_read", sr[0], !r.wr);
      chk("w0_byte", sb[0], r.byt);
      if (r.wr) chk("w0_wdata", sd[0], r.wd);
    end
    if (n >= 2 && exp_n >= 2) begin
      chk("w1_cycle", sc[1], 32'd2);
      chk("w1_addr", sa[1], r.addr + 32'd4);
      chk("w1_write", sw[1], r.wr);
      chk("w1_read", sr[1], !r.wr);
      if (r.wr) chk("w1_wdata", sd[1], r.wd2);
    end

    if (legal) begin
      if (r.wr) begin
        if (r.byt) begin
          lane = 3 - int'(r.addr[1:0]);
          ref_mem[r.addr[7:2]][8*lane +: 8] = r.wd[7:0];
        end else begin
          ref_mem[r.addr[7:2]] = r.wd;
          if (r.dbl) ref_mem[r.addr[7:2] + 6'd1] = r.wd2;
        end
      end else begin
        ref_rd = ref_mem[r.addr[7:2]];
        if (r.dbl) ref_rd2 = ref_mem[r.addr[7:2] + 6'd1];
      end
    end
    exp_strobe_cnt += exp_n;

    chk("addr_err", got_err, !legal);
    chk("resp_rdata", got_rd, ref_rd);
    chk("resp_rdata2", got_rd2, ref_rd2);

    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  vec_t        vecs [16];
  logic        e;
  logic [31:0] d, d2;
  req_t        rr;

  initial begin
    for (int i = 0; i < 64; i++) begin
      tmem[i] = '0;
      ref_mem[i] = '0;
    end
    tmem[2] = 32'h0000000C;
    ref_mem[2] = 32'h0000000C;
    ref_rd = '0; ref_rd2 = '0;
    mem_rdata = '0;
    req_valid = 0; req_write = 0; req_double = 0; req_byte = 0;
    req_addr = '0; req_wdata = '0; req_wdata2 = '0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_strobes", {mem_write, mem_read, mem_store_byte}, 3'b000);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_rdata2", resp_rdata2, 32'd0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- directed vector table (back-to-back, req held over resp) ----------------
    vecs[0]  = mkv(mkr(0,0,0, 32'd8,  32'h0, 32'h0),                 0, 32'h0000000C, 32'h0);
    vecs[1]  = mkv(mkr(1,1,0, 32'd16, 32'hAAAA5555, 32'h12345678),   0, 32'h0000000C, 32'h0);
    vecs[2]  = mkv(mkr(0,1,0, 32'd16, 32'h0, 32'h0),                 0, 32'hAAAA5555, 32'h12345678);
    vecs[3]  = mkv(mkr(1,0,1, 32'd5,  32'h000000EF, 32'h0),          0, 32'hAAAA5555, 32'h12345678);
    vecs[4]  = mkv(mkr(0,0,0, 32'd4,  32'h0, 32'h0),                 0, 32'h00EF0000, 32'h12345678);
    vecs[5]  = mkv(mkr(0,0,0, 32'd6,  32'h0, 32'h0),                 1, 32'h00EF0000, 32'h12345678);
    vecs[6]  = mkv(mkr(0,1,0, 32'd4,  32'h0, 32'h0),                 1, 32'h00EF0000, 32'h12345678);
    vecs[7]  = mkv(mkr(0,0,1, 32'd0,  32'h0, 32'h0),                 1, 32'h00EF0000, 32'h12345678);
    vecs[8]  = mkv(mkr(1,0,0, 32'd12, 32'hDEADBEEF, 32'h0),          0, 32'h00EF0000, 32'h12345678);
    vecs[9]  = mkv(mkr(1,0,1, 32'd12, 32'h00000011, 32'h0),          0, 32'h00EF0000, 32'h12345678);
    vecs[10] = mkv(mkr(1,0,1, 32'd15, 32'h00000022, 32'h0),          0, 32'h00EF0000, 32'h12345678);
    vecs[11] = mkv(mkr(0,0,0, 32'd12, 32'h0, 32'h0),                 0, 32'h11ADBE22, 32'h12345678);
    vecs[12] = mkv(mkr(1,1,0, 32'd12, 32'h1, 32'h2),                 1, 32'h11ADBE22, 32'h12345678);
    vecs[13] = mkv(mkr(1,0,1, 32'd0,  32'hFFFFFF77, 32'h0),          0, 32'h11ADBE22, 32'h12345678);
    vecs[14] = mkv(mkr(0,0,0, 32'd0,  32'h0, 32'h0),                 0, 32'h77000000, 32'h12345678);
    vecs[15] = mkv(mkr(0,1,0, 32'd8,  32'h0, 32'h0),                 0, 32'h0000000C, 32'h11ADBE22);

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].rq, e, d, d2);
      chk($sformatf("vec%0d_err", i), e, vecs[i].err);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].rd);
      chk($sformatf("vec%0d_rdata2", i), d2, vecs[i].rd2);
    end

    // ---------------- reset during W1 of a double load ----------------
    req_valid = 1'b1; req_write = 1'b0; req_double = 1'b1; req_byte = 1'b0;
    req_addr = 32'd16; req_wdata = '0; req_wdata2 = '0;
    @(posedge clk);  // accept -> W0
    @(posedge clk);  // W0 -> W1
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("midrst_mem_read", mem_read, 1'b0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_rdata2", resp_rdata2, 32'd0);
    chk("midrst_stall", stall, 1'b0);
    ref_rd = '0; ref_rd2 = '0;
    exp_strobe_cnt += 1;  // the W0 read strobe of the abandoned access
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    do_req(mkr(0,0,0, 32'd16, 32'h0, 32'h0), e, d, d2);
    chk("postrst_rdata", d, 32'hAAAA5555);
    chk("postrst_rdata2", d2, 32'h0);

    // ---------------- randomized requests vs reference model ----------------
    for (int i = 0; i < 80; i++) begin
      rr.wr   = 1'($urandom_range(0, 1));
      rr.dbl  = ($urandom_range(0, 3) == 0);
      rr.byt  = !rr.dbl && ($urandom_range(0, 3) == 0);
      rr.addr = 32'($urandom_range(0, 63)) << 2;
      if (rr.dbl && $urandom_range(0, 3) != 0) rr.addr[2] = 1'b0;
      if ($urandom_range(0, 4) == 0) rr.addr[1:0] = 2'($urandom_range(1, 3));
      if (rr.byt) rr.addr[1:0] = 2'($urandom_range(0, 3));
      rr.wd   = $urandom;
      rr.wd2  = $urandom;
      do_req(rr, e, d, d2);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    chk("total_strobes", strobe_cnt, exp_strobe_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
